mod_stream_checker: RTL and testbench
=====================================

MOD_STREAM_CHECKER -- requirements
Module: mod_stream_checker

Interface
REQ-001 SHALL have parameter DW, default 4: divisor and residue width in bits; legal range 2..16.
REQ-002 SHALL have parameter CW, default 8: bit-counter width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begins a new frame and samples divisor.
REQ-006 SHALL have port divisor, input, DW: modulus N; sampled only in a cycle with start=1.
REQ-007 SHALL have port bit_valid, input, 1: bit_in is qualified this cycle.
REQ-008 SHALL have port bit_in, input, 1: next stream bit, MSB first.
REQ-009 SHALL have port residue, output, DW: registered value mod N of the bits accepted so far.
REQ-010 SHALL have port divisible, output, 1: registered; 1 when state is RUN and residue==0.
REQ-011 SHALL have port div_now, output, 1: combinational Mealy flag; 1 when bit_valid=1, state is RUN (or start=1 with a legal divisor) and the next residue is 0.
REQ-012 SHALL have port bit_count, output, CW: number of bits accepted in the current frame, saturating.
REQ-013 SHALL have port busy, output, 1: 1 in RUN.
REQ-014 SHALL have port err, output, 1: 1 in ERR.

Function
REQ-015 SHALL implement the states IDLE, RUN and ERR; IDLE on reset.
REQ-016 SHALL, when start=1 in any state with sampled divisor >= 1, latch N, clear residue and bit_count, and enter RUN.
REQ-017 SHALL, when start=1 with divisor==0, enter ERR and hold residue=0 and bit_count=0.
REQ-018 SHALL ignore bit_valid in IDLE and ERR; only start or reset leaves ERR.
REQ-019 SHALL, in RUN with bit_valid=1, update residue to (2*residue + bit_in) mod N using one DW+1-bit add and one conditional subtract of N (the pre-update residue is always < N).
REQ-020 SHALL, when start and bit_valid coincide with a legal divisor, treat bit_in as the first bit of the new frame: residue = bit_in mod N, bit_count = 1.
REQ-021 SHALL hold residue and bit_count unchanged in RUN when bit_valid=0.
REQ-022 SHALL saturate bit_count at 2^CW-1 while residue continues to update.
REQ-023 SHALL, for N==1, keep residue at 0 and divisible at 1 throughout RUN.
REQ-024 SHALL assert divisible for an empty RUN frame (bit_count==0), since value 0 is divisible.
REQ-025 SHALL update all registered outputs one cycle after the accepted bit; div_now has zero latency.

Reset
REQ-026 SHALL, on reset=1 at any time including mid-frame, immediately force state IDLE, residue 0, stored N 0, bit_count 0, busy 0, divisible 0 and err 0.
REQ-027 SHALL ignore start and bit_valid while reset=1; the first frame after reset needs a fresh start.

Structure
REQ-028 SHALL place the state enumeration (IDLE/RUN/ERR) and the DW/CW default constants in the shared package mod_stream_pkg.
REQ-029 SHALL factor the one-bit residue update into combinational sub-module mod_step (inputs: residue, bit, N; output: next residue), shared by the registered path and div_now.

Verification
REQ-030 SHALL cover: N=3, start, then bits 1,1,0 (6) -> residue 0, divisible=1, bit_count=3; div_now=1 on the third bit.
REQ-031 SHALL cover: N=5, bits 1,1,0,1 (13) -> residue 3, divisible=0; then a new start with N=7 and bits 1,1,1 (7) -> residue 0.
REQ-032 SHALL cover: start with divisor=0 -> err=1, busy=0; four following bits are ignored, residue=0; start with N=3 -> err=0, busy=1.
REQ-033 SHALL cover: start and bit_valid in the same cycle with bit_in=1, N=3 -> residue 1, bit_count 1; reset asserted mid-frame -> all outputs 0 asynchronously, state IDLE.
REQ-034 SHALL cover: DW=4, N=15, 8 ones (255) -> residue 0; and CW=3, 10 bits -> bit_count holds at 7 while residue stays correct.
REQ-035 SHALL cover: N=1, random bits -> residue 0 and divisible=1 on every cycle; bit_valid gaps of 0..3 cycles -> results identical to back-to-back bits.

Source files
------------

// File: rtl/mod_stream_pkg.sv
// Shared types and default widths for the modular stream checker.
// Holds the frame-state encoding and the default parameter values.
package mod_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int DW_DEFAULT = 4;
  localparam int CW_DEFAULT = 8;

endpackage

// File: rtl/mod_step.sv
// One MSB-first residue step: (2*residue + bit_in) mod n.
// Relies on residue < n, so a single conditional subtract is enough.
module mod_step
  import mod_stream_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] residue,
  input  logic          bit_in,
  input  logic [DW-1:0] n,
  output logic [DW-1:0] next_residue
);

  logic [DW:0]   doubled;
  logic [DW-1:0] diff;

  assign doubled      = {residue, bit_in};
  // When doubled >= n the true difference is < n, so it fits in DW bits.
  assign diff         = DW'(doubled - {1'b0, n});
  assign next_residue = (doubled >= {1'b0, n}) ? diff : doubled[DW-1:0];

endmodule

// File: rtl/mod_stream_checker.sv
// Tracks the value of an MSB-first bit stream modulo a per-frame divisor,
// with a registered residue/divisible flag and a zero-latency div_now flag.
module mod_stream_checker
  import mod_stream_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] divisor,
  input  logic          bit_valid,
  input  logic          bit_in,
  output logic [DW-1:0] residue,
  output logic          divisible,
  output logic          div_now,
  output logic [CW-1:0] bit_count,
  output logic          busy,
  output logic          err
);

  state_t        state, state_next;
  logic [DW-1:0] n_latched, n_next;
  logic [DW-1:0] residue_next;
  logic [CW-1:0] count_next;
  logic          divisible_next;

  logic [DW-1:0] step_residue;
  logic [DW-1:0] step_n;
  logic [DW-1:0] step_out;
  logic          legal_start;

  assign legal_start = start && (divisor != '0);

  // A start restarts the frame from residue 0 against the incoming divisor,
  // so the same step serves both the first bit of a frame and later bits.
  assign step_residue = start ? '0 : residue;
  assign step_n       = start ? divisor : n_latched;

  mod_step #(.DW(DW)) u_step (
    .residue      (step_residue),
    .bit_in       (bit_in),
    .n            (step_n),
    .next_residue (step_out)
  );

  assign div_now = !reset && bit_valid && (step_out == '0) &&
                   (legal_start || (!start && state == RUN));

  assign busy = (state == RUN);
  assign err  = (state == ERR);

  always_comb begin
    state_next   = state;
    n_next       = n_latched;
    residue_next = residue;
    count_next   = bit_count;
    if (start) begin
      if (legal_start) begin
        state_next   = RUN;
        n_next       = divisor;
        residue_next = bit_valid ? step_out : '0;
        count_next   = bit_valid ? CW'(1) : '0;
      end else begin
        state_next   = ERR;
        n_next       = '0;
        residue_next = '0;
        count_next   = '0;
      end
    end else if (state == RUN && bit_valid) begin
      residue_next = step_out;
      if (bit_count != '1) begin
        count_next = bit_count + CW'(1);
      end
    end
    divisible_next = (state_next == RUN) && (residue_next == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n_latched <= '0;
      residue   <= '0;
      bit_count <= '0;
      divisible <= 1'b0;
    end else begin
      state     <= state_next;
      n_latched <= n_next;
      residue   <= residue_next;
      bit_count <= count_next;
      divisible <= divisible_next;
    end
  end

endmodule

// File: tb/tb_mod_stream_checker.sv
// Directed checks of mod_stream_checker; a second instance with CW=3
// shares the stimulus to exercise bit-counter saturation.
module tb_mod_stream_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] divisor = 4'd0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;

  logic [3:0] residue;
  logic       divisible, div_now, busy, err;
  logic [7:0] bit_count;

  logic [3:0] residue3;
  logic       divisible3, div_now3, busy3, err3;
  logic [2:0] bit_count3;

  int total = 0;
  int bad = 0;
  logic dn;

  always #5 clk = ~clk;

  mod_stream_checker #(.DW(4), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .divisor(divisor),
    .bit_valid(bit_valid), .bit_in(bit_in), .residue(residue),
    .divisible(divisible), .div_now(div_now), .bit_count(bit_count),
    .busy(busy), .err(err)
  );

  mod_stream_checker #(.DW(4), .CW(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .divisor(divisor),
    .bit_valid(bit_valid), .bit_in(bit_in), .residue(residue3),
    .divisible(divisible3), .div_now(div_now3), .bit_count(bit_count3),
    .busy(busy3), .err(err3)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; dn holds div_now as seen just before the edge.
  task automatic cyc(input logic s, input logic [3:0] d, input logic v, input logic b);
    @(negedge clk);
    start = s; divisor = d; bit_valid = v; bit_in = b;
    #1 dn = div_now;
    @(posedge clk);
    #1;
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    $display("cyc start=%0b div=%0d v=%0b b=%0b -> res=%0d dvs=%0b dn=%0b cnt=%0d busy=%0b err=%0b",
             s, d, v, b, residue, divisible, dn, bit_count, busy, err);
  endtask

  task automatic bitv(input logic b);
    cyc(1'b0, 4'd0, 1'b1, b);
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [4:0] bits23;
    int gaps [5];

    // Reset state
    #2;
    chk4("rst_residue", residue, 4'd0);
    chk1("rst_divisible", divisible, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk8("rst_count", bit_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // N=3, 1,1,0 -> 6
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    chk1("n3_busy", busy, 1'b1);
    chk1("n3_empty_divisible", divisible, 1'b1);
    chk8("n3_empty_count", bit_count, 8'd0);
    bitv(1'b1);
    chk4("n3_b1_residue", residue, 4'd1);
    chk1("n3_b1_dn", dn, 1'b0);
    bitv(1'b1);
    bitv(1'b0);
    chk1("n3_b3_dn", dn, 1'b1);
    chk4("n3_residue", residue, 4'd0);
    chk1("n3_divisible", divisible, 1'b1);
    chk8("n3_count", bit_count, 8'd3);

    // N=5, 1,1,0,1 -> 13 mod 5 = 3; then N=7, 1,1,1 -> 0
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    bitv(1'b1); bitv(1'b1); bitv(1'b0); bitv(1'b1);
    chk1("n5_dn", dn, 1'b0);
    chk4("n5_residue", residue, 4'd3);
    chk1("n5_divisible", divisible, 1'b0);
    chk8("n5_count", bit_count, 8'd4);
    cyc(1'b1, 4'd7, 1'b0, 1'b0);
    chk8("n7_restart_count", bit_count, 8'd0);
    bitv(1'b1); bitv(1'b1); bitv(1'b1);
    chk1("n7_dn", dn, 1'b1);
    chk4("n7_residue", residue, 4'd0);
    chk1("n7_divisible", divisible, 1'b1);

    // divisor 0 -> ERR, bits ignored
    cyc(1'b1, 4'd0, 1'b0, 1'b0);
    chk1("err_err", err, 1'b1);
    chk1("err_busy", busy, 1'b0);
    chk1("err_divisible", divisible, 1'b0);
    for (int i = 0; i < 4; i++) bitv(1'b1);
    chk1("err_dn", dn, 1'b0);
    chk4("err_residue", residue, 4'd0);
    chk8("err_count", bit_count, 8'd0);
    chk1("err_hold", err, 1'b1);
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    chk1("err_exit_err", err, 1'b0);
    chk1("err_exit_busy", busy, 1'b1);

    // start + bit in same cycle, then async reset mid-frame
    cyc(1'b1, 4'd3, 1'b1, 1'b1);
    chk1("sb_dn", dn, 1'b0);
    chk4("sb_residue", residue, 4'd1);
    chk8("sb_count", bit_count, 8'd1);
    bitv(1'b0);
    chk4("sb_b2_residue", residue, 4'd2);
    chk8("sb_b2_count", bit_count, 8'd2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk4("ar_residue", residue, 4'd0);
    chk8("ar_count", bit_count, 8'd0);
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_err", err, 1'b0);
    chk1("ar_divisible", divisible, 1'b0);
    cyc(1'b1, 4'd3, 1'b1, 1'b0);
    chk1("ar_start_ignored_dn", dn, 1'b0);
    chk1("ar_start_ignored", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bitv(1'b1);
    chk1("idle_bit_busy", busy, 1'b0);
    chk4("idle_bit_residue", residue, 4'd0);
    chk8("idle_bit_count", bit_count, 8'd0);

    // N=15, 8 ones -> 255 mod 15 = 0; CW=3 counter saturates at 7
    cyc(1'b1, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bitv(1'b1);
    chk4("n15_residue", residue, 4'd0);
    chk1("n15_divisible", divisible, 1'b1);
    chk8("n15_count", bit_count, 8'd8);
    chk4("n15_count3", {1'b0, bit_count3}, 4'd7);
    bitv(1'b1);
    bitv(1'b0);
    chk4("sat_residue3", residue3, 4'd2);
    chk4("sat_count3", {1'b0, bit_count3}, 4'd7);
    chk8("sat_count", bit_count, 8'd10);

    // N=1: residue stays 0, divisible stays 1
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    chk1("n1_empty_divisible", divisible, 1'b1);
    pat = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      bitv(pat[i]);
      chk4("n1_residue", residue, 4'd0);
      chk1("n1_divisible", divisible, 1'b1);
      chk1("n1_dn", dn, 1'b1);
    end

    // N=5 with gaps, bits 1,0,1,1,1 = 23 -> 3
    bits23 = 5'b10111;
    gaps = '{1, 0, 3, 2, 0};
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      bitv(bits23[i]);
      for (int g = 0; g < gaps[i]; g++) begin
        idle();
        chk1("gap_dn", dn, 1'b0);
      end
    end
    chk4("gap_residue", residue, 4'd3);
    chk8("gap_count", bit_count, 8'd5);
    chk1("gap_divisible", divisible, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
